// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller.
// Presents candidate values to an external magnitude comparator and settles
// on the unknown target one bit at a time, MSB first. An eq verdict ends the
// search early. A verdict that is not one-hot aborts the search with err set.
//
// state | meaning
// IDLE  | waiting for start; result/found/err hold the last search outcome
// DRIVE | guess presented, waiting for an accepted verdict
// DONE  | one-cycle done pulse; result/found/err valid
module sar_search #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] guess_o,
    output logic             guess_valid_o,
    input  logic             cmp_valid_i,
    input  logic             cmp_gt_i,
    input  logic             cmp_lt_i,
    input  logic             cmp_eq_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             found_o,
    output logic             err_o
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] guess_q;
    logic             guess_valid_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             found_q;
    logic             err_q;

    logic [WIDTH-1:0] next_mask_d;
    logic [2:0]       verdict_d;

    // Bit one below the current index (only used when idx_q != 0) and the
    // packed verdict, ordered {gt, lt, eq}.
    always_comb begin
        next_mask_d = WIDTH'(1) << (idx_q - IW'(1));
        verdict_d   = {cmp_gt_i, cmp_lt_i, cmp_eq_i};
    end

    // Search FSM; all outputs are registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            r_q           <= '0;
            guess_q       <= '0;
            guess_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            found_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q       <= DRIVE;
                        idx_q         <= IW'(WIDTH - 1);
                        r_q           <= '0;
                        guess_q       <= WIDTH'(1) << (WIDTH - 1);
                        guess_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        result_q      <= '0;
                        found_q       <= 1'b0;
                        err_q         <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (guess_valid_q && cmp_valid_i) begin
                        case (verdict_d)
                            3'b001: begin
                                r_q           <= guess_q;
                                result_q      <= guess_q;
                                found_q       <= 1'b1;
                                state_q       <= DONE;
                                guess_valid_q <= 1'b0;
                                busy_q        <= 1'b0;
                                done_q        <= 1'b1;
                            end
                            3'b100: begin
                                // guess too high: bit stays clear in r
                                if (idx_q == '0) begin
                                    result_q      <= r_q;
                                    state_q       <= DONE;
                                    guess_valid_q <= 1'b0;
                                    busy_q        <= 1'b0;
                                    done_q        <= 1'b1;
                                end else begin
                                    idx_q   <= idx_q - IW'(1);
                                    guess_q <= r_q | next_mask_d;
                                end
                            end
                            3'b010: begin
                                // guess too low: keep the bit
                                r_q <= guess_q;
                                if (idx_q == '0) begin
                                    result_q      <= guess_q;
                                    state_q       <= DONE;
                                    guess_valid_q <= 1'b0;
                                    busy_q        <= 1'b0;
                                    done_q        <= 1'b1;
                                end else begin
                                    idx_q   <= idx_q - IW'(1);
                                    guess_q <= guess_q | next_mask_d;
                                end
                            end
                            default: begin
                                // not one-hot: abort with the bits decided so far
                                err_q         <= 1'b1;
                                result_q      <= r_q;
                                state_q       <= DONE;
                                guess_valid_q <= 1'b0;
                                busy_q        <= 1'b0;
                                done_q        <= 1'b1;
                            end
                        endcase
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q       <= IDLE;
                    guess_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign guess_o       = guess_q;
    assign guess_valid_o = guess_valid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign found_o       = found_q;
    assign err_o         = err_q;

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller: the initiating side of the team's magnitude comparators. It drives candidate values to an external comparator, consumes its gt/lt/eq verdicts, and converges bit-by-bit (MSB first) on an unknown target value held on the comparator's other input. It sits beside a comparator in threshold-finding, ADC-style and calibration datapaths. When the comparator reports eq, the search ends early.

## Interface
- WIDTH, 8: width of guess/result and number of search steps (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new search; sampled only in IDLE.
- guess  out  WIDTH  candidate value presented to the comparator.
- guess_valid  out  1  guess is stable and awaiting a verdict.
- cmp_valid  in  1  verdict valid this cycle; may be tied to guess_valid for a combinational comparator.
- cmp_gt  in  1  guess > target.
- cmp_lt  in  1  guess < target.
- cmp_eq  in  1  guess == target.
- busy  out  1  search in progress (DRIVE state).
- done  out  1  one-cycle pulse: result/found/err are valid.
- result  out  WIDTH  search result; held until next start.
- found  out  1  search ended on an eq verdict.
- err  out  1  illegal verdict (not one-hot) terminated the search.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: on start, go to DRIVE. Set bit index i = WIDTH-1, working value r = 0, and clear found/err.
- DRIVE:
  - guess = r | (1<<i), with guess_valid = 1.
  - A verdict is accepted on a cycle with guess_valid && cmp_valid.
  - If no verdict is accepted, hold guess, i and r unchanged for any number of cycles.
- Verdict handling:
  - eq only: r = guess, found = 1, go to DONE.
  - gt only: bit i stays 0 in r.
  - lt only: r = guess (bit i kept).
  - Any other combination (none set, or more than one set): err = 1, result = r as it was before this step, go to DONE.
  - After a gt or lt verdict: if i == 0, go to DONE; else decrement i.
- DONE: result = r, done = 1 for exactly one cycle, then return to IDLE.
- Arithmetic: unsigned, WIDTH bits, no carry out.
  - With consistent verdicts, result always equals the target.
  - found = 0 only when the target's step was never tested exactly. Example: target 0 ends by gt on the LSB, and result = 0 still.
- start while busy or in DONE is ignored. No queuing.
- start on the cycle done is high is ignored. start is accepted from the following IDLE cycle.
- err has priority over eq. A verdict with eq and gt both set is an error.

## Timing
- Reset values: state IDLE, guess 0, guess_valid 0, busy 0, done 0, result 0, found 0, err 0.
- Reset mid-search aborts immediately. No done is issued, and the block is back in IDLE on deassertion.
- start sampled high in cycle 0 puts the first guess (1<<(WIDTH-1)) on guess with guess_valid high in cycle 1.
- A verdict accepted in cycle t:
  - The next guess appears in cycle t+1, and guess_valid stays high between steps.
  - If the verdict was terminal, done is high in cycle t+1.
- With cmp_valid tied high:
  - Full search: done in cycle WIDTH+1.
  - Early eq at step k (k = 1 for the first step): done in cycle k+1.
- busy = 1 exactly while in DRIVE. busy = 0 during the done cycle.
- guess_valid = 0 outside DRIVE. guess keeps its last value when guess_valid = 0.
- result, found and err are registered and stable from the done cycle until the next accepted start. They clear on the cycle after the next start is accepted.

## Test plan
- Target 100, WIDTH=8, cmp_valid tied high, behavioural comparator.
  - Required guess sequence: 128, 64, 96, 112, 104, 100.
  - Eq at step 6; done in cycle 7; result=100, found=1, err=0.
- Target 0: all guesses gt, LSB guess 1 gives gt. Done in cycle 9; result=0, found=0.
- Target 255: all verdicts lt, last guess 255 gives eq. Done in cycle 9; result=255, found=1.
- Target 128: first verdict eq. Done in cycle 2; result=128, found=1.
- Target 77, with cmp_valid low for 3 random cycles before each verdict:
  - guess must hold steady during each stall.
  - result=77; done latency = 9 + total stall cycles.
- Fault and interference cases:
  - Force gt=lt=1 at step 3: err=1, done next cycle, result = bits decided in steps 1–2.
  - Pulse start mid-search: no effect.
  - Assert rst mid-search: all outputs 0, no done, and a new start works.
